// File: rtl/usb_rw_pkg.sv
// Shared types and constants for the USB memory read/write sequencer.
package usb_rw_pkg;

    typedef enum logic [2:0] {
        IDLE,
        A_ISSUE,
        A_WAIT,
        D_ISSUE,
        D_WAIT,
        FINISH
    } rw_state_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } rw_op_t;

    localparam logic [3:0] ADDR_ENDP_DEF = 4'd4;
    localparam logic [3:0] DATA_ENDP_DEF = 4'd8;
    localparam int         ADDR_PAD_W    = 48;

endpackage

// File: rtl/counter.sv
// Generic saturating-free up counter with synchronous clear (clear wins over increment).
// Latency: count updates on the clock edge after clr/inc.
// Backpressure: none; the caller bounds the count.
module counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_L,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/usb_txn_tracker.sv
// One ProtocolFSM transaction: issue strobe, seen_busy tracking, completion/cancel detect.
// Latency: input_ready is registered, one cycle after the issue cycle that saw free.
// Backpressure: issue stalls while free is low; free before the FSM has gone busy is not completion.
module usb_txn_tracker (
    input  logic clk,
    input  logic rst_L,
    input  logic issue_en,
    input  logic wait_en,
    input  logic free,
    input  logic cancel,
    output logic fire,
    output logic input_ready,
    output logic txn_done,
    output logic txn_cancel
);

    logic seen_busy;

    assign fire       = issue_en && free;
    assign txn_done   = wait_en && free && seen_busy;
    assign txn_cancel = wait_en && cancel;

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            input_ready <= 1'b0;
            seen_busy   <= 1'b0;
        end else begin
            input_ready <= fire;
            if (fire) begin
                seen_busy <= 1'b0;
            end else if (wait_en && !free) begin
                seen_busy <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/usb_rw_ctrl.sv
// Splits a memory read/write into an address OUT then a data IN/OUT; USB_RW_RETRY_EN adds whole-request retry.
// Latency: at least 6 cycles from acceptance to the done pulse.
// Backpressure: each issue waits for free; requests seen while busy are dropped, never queued.
module usb_rw_ctrl
    import usb_rw_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR  = 7'd5,
    parameter logic [3:0] ADDR_ENDP = ADDR_ENDP_DEF,
    parameter logic [3:0] DATA_ENDP = DATA_ENDP_DEF
`ifdef USB_RW_RETRY_EN
    ,
    parameter int         MAX_RETRY = 2
`endif
) (
    input  logic        clk,
    input  logic        rst_L,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [15:0] mem_addr,
    input  logic [63:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        success,
    output logic [63:0] rd_data,
    output logic        send_in,
    output logic        input_ready,
    output logic [63:0] proto_data,
    output logic [6:0]  proto_addr,
    output logic [3:0]  proto_endp,
    output logic        got_result,
    input  logic        free,
    input  logic        cancel,
    input  logic        recv_ready,
    input  logic [63:0] data_recv
);

    rw_state_t   state, state_n;
    rw_op_t      op;
    logic [15:0] addr_q;
    logic [63:0] wdat_q;
    logic        got_data, success_q;
    logic        issue_en, wait_en, fire, txn_done, txn_cancel;
    logic        accept, finish_ok, finish_fail, restart, retry_ok;
    logic        capture, have_data;

    assign issue_en  = (state == A_ISSUE) || (state == D_ISSUE);
    assign wait_en   = (state == A_WAIT)  || (state == D_WAIT);
    assign capture   = (state == D_WAIT) && (op == OP_READ) && !got_data && recv_ready;
    assign have_data = got_data || capture;

    assign busy    = issue_en || wait_en;
    assign done    = (state == FINISH);
    assign success = done && success_q;

    usb_txn_tracker u_trk (
        .clk        (clk),
        .rst_L      (rst_L),
        .issue_en   (issue_en),
        .wait_en    (wait_en),
        .free       (free),
        .cancel     (cancel),
        .fire       (fire),
        .input_ready(input_ready),
        .txn_done   (txn_done),
        .txn_cancel (txn_cancel)
    );

`ifdef USB_RW_RETRY_EN
    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    logic [RETRY_W-1:0] retry_cnt;

    counter #(.W(RETRY_W)) u_retry_cnt (
        .clk  (clk),
        .rst_L(rst_L),
        .clr  (accept),
        .inc  (restart),
        .cnt  (retry_cnt)
    );

    assign retry_ok = (retry_cnt < RETRY_W'(MAX_RETRY));
`else
    assign retry_ok = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n     = state;
        accept      = 1'b0;
        finish_ok   = 1'b0;
        finish_fail = 1'b0;
        restart     = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_read || req_write) begin
                    accept  = 1'b1;
                    state_n = A_ISSUE;
                end
            end
            A_ISSUE: if (fire) state_n = A_WAIT;
            D_ISSUE: if (fire) state_n = D_WAIT;
            A_WAIT, D_WAIT: begin
                // Cancel outranks a coincident free so a dropped transaction never looks complete.
                if (txn_cancel) begin
                    if (retry_ok) begin
                        restart = 1'b1;
                        state_n = A_ISSUE;
                    end else begin
                        finish_fail = 1'b1;
                        state_n     = FINISH;
                    end
                end else if (txn_done) begin
                    if (state == A_WAIT) begin
                        state_n = D_ISSUE;
                    end else begin
                        finish_ok   = (op == OP_WRITE) || have_data;
                        finish_fail = (op == OP_READ) && !have_data;
                        state_n     = FINISH;
                    end
                end
            end
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            op         <= OP_READ;
            addr_q     <= '0;
            wdat_q     <= '0;
            got_data   <= 1'b0;
            success_q  <= 1'b0;
            got_result <= 1'b0;
            rd_data    <= '0;
            send_in    <= 1'b0;
            proto_data <= '0;
            proto_addr <= DEV_ADDR;
            proto_endp <= ADDR_ENDP;
        end else begin
            got_result <= capture;
            if (accept) begin
                op        <= req_read ? OP_READ : OP_WRITE;
                addr_q    <= mem_addr;
                wdat_q    <= wr_data;
                got_data  <= 1'b0;
                success_q <= 1'b0;
            end
            if (capture) begin
                rd_data  <= data_recv;
                got_data <= 1'b1;
            end
            if (finish_ok || finish_fail) begin
                success_q <= finish_ok;
            end
            // Mux controls only move on an issue, so they stay put for the whole transaction.
            if (fire) begin
                proto_addr <= DEV_ADDR;
                if (state == A_ISSUE) begin
                    send_in    <= 1'b0;
                    proto_endp <= ADDR_ENDP;
                    proto_data <= {{ADDR_PAD_W{1'b0}}, addr_q};
                end else begin
                    send_in    <= (op == OP_READ);
                    proto_endp <= DATA_ENDP;
                    if (op == OP_WRITE) begin
                        proto_data <= wdat_q;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_usb_rw_ctrl.sv
// Bench for usb_rw_ctrl: a ProtocolFSM responder with random timing plus a request-level expectation model.
module tb_usb_rw_ctrl;

`ifdef USB_RW_RETRY_EN
    localparam int MAX_R = 2;
`else
    localparam int MAX_R = 0;
`endif

    logic        clk, rst_L;
    logic        req_read, req_write;
    logic [15:0] mem_addr;
    logic [63:0] wr_data;
    logic        busy, done, success;
    logic [63:0] rd_data;
    logic        send_in, input_ready;
    logic [63:0] proto_data;
    logic [6:0]  proto_addr;
    logic [3:0]  proto_endp;
    logic        got_result;
    logic        free, cancel, recv_ready;
    logic [63:0] data_recv;

    usb_rw_ctrl dut (
        .clk        (clk),
        .rst_L      (rst_L),
        .req_read   (req_read),
        .req_write  (req_write),
        .mem_addr   (mem_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .success    (success),
        .rd_data    (rd_data),
        .send_in    (send_in),
        .input_ready(input_ready),
        .proto_data (proto_data),
        .proto_addr (proto_addr),
        .proto_endp (proto_endp),
        .got_result (got_result),
        .free       (free),
        .cancel     (cancel),
        .recv_ready (recv_ready),
        .data_recv  (data_recv)
    );

    typedef struct {
        logic        si;
        logic [3:0]  ep;
        logic [63:0] d;
        logic [6:0]  a;
    } txn_t;

    txn_t        log_q[$];
    int          total = 0;
    int          bad   = 0;
    int          gr_count;
    int          cancel_budget;
    logic [63:0] rd_value;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    // ProtocolFSM stand-in: random delay before going busy, random busy length, IN data near the end.
    initial begin
        int   pre_left, busy_left;
        bit   active, cur_in, cur_cancel;
        txn_t t;
        free = 1'b1; cancel = 1'b0; recv_ready = 1'b0; data_recv = '0;
        pre_left = 0; busy_left = 0; active = 0; cur_in = 0; cur_cancel = 0;
        gr_count = 0; cancel_budget = 0; rd_value = '0;
        forever begin
            @(negedge clk);
            if (!rst_L) begin
                free = 1'b1; cancel = 1'b0; recv_ready = 1'b0;
                pre_left = 0; busy_left = 0; active = 0;
            end else begin
                if (got_result) begin
                    gr_count++;
                    recv_ready = 1'b0;
                end
                if (cancel) cancel = 1'b0;
                if (active && pre_left > 0) begin
                    pre_left--;
                    if (pre_left == 0) free = 1'b0;
                end else if (active && busy_left > 0) begin
                    busy_left--;
                    if (busy_left == 1 && cur_in && !cur_cancel) begin
                        recv_ready = 1'b1;
                        data_recv  = rd_value;
                    end
                    if (busy_left == 0) begin
                        free   = 1'b1;
                        active = 0;
                        if (cur_cancel) cancel = 1'b1;
                    end
                end else if (input_ready) begin
                    t.si = send_in; t.ep = proto_endp; t.d = proto_data; t.a = proto_addr;
                    log_q.push_back(t);
                    active     = 1;
                    cur_in     = send_in;
                    cur_cancel = (cancel_budget > 0) && (proto_endp == 4'd8);
                    if (cur_cancel) cancel_budget--;
                    busy_left  = $urandom_range(2, 5);
                    pre_left   = $urandom_range(0, 2);
                    if (pre_left == 0) free = 1'b0;
                end
            end
        end
    end

    task automatic run_req(input bit rd, input bit both, input bit wr_busy, input logic [15:0] a,
                           input logic [63:0] wd, input logic [63:0] rv, input int ncan);
        int   k, attempts, n;
        bit   seen, eff_rd, exp_ok;
        txn_t e;
        eff_rd   = rd || both;
        exp_ok   = (ncan <= MAX_R);
        attempts = exp_ok ? ncan + 1 : MAX_R + 1;
        @(negedge clk);
        log_q.delete();
        gr_count = 0; rd_value = rv; cancel_budget = ncan;
        req_read = rd || both; req_write = !rd || both; mem_addr = a; wr_data = wd;
        @(negedge clk);
        req_read = 1'b0; req_write = wr_busy;
        mem_addr = 16'($urandom); wr_data = {$urandom, $urandom};
        chk("busy_after_accept", busy, 1);
        k = 1; seen = 0;
        while (!seen && k < 400) begin
            if (done) seen = 1;
            else begin
                @(negedge clk);
                k++;
                if (k == 4) req_write = 1'b0;
            end
        end
        req_write = 1'b0;
        chk("done_seen", seen, 1);
        if (seen) begin
            chk("success", success, exp_ok);
            chk("busy_at_done", busy, 0);
            chk("latency_ge6", k >= 6, 1);
            if (eff_rd && exp_ok) chk("rd_data", rd_data, rv);
        end
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("idle_after_done", busy, 0);
        repeat (3) @(negedge clk);
        chk("no_requeue", busy, 0);
        chk("input_ready_count", log_q.size(), 2 * attempts);
        chk("got_result_count", gr_count, (eff_rd && exp_ok) ? 1 : 0);
        n = (log_q.size() < 2 * attempts) ? log_q.size() : 2 * attempts;
        for (int i = 0; i < n; i++) begin
            e = log_q[i];
            chk("txn_send_in", e.si, (i % 2 == 1) ? eff_rd : 1'b0);
            chk("txn_endp", e.ep, (i % 2 == 1) ? 4'd8 : 4'd4);
            chk("txn_addr", e.a, 7'd5);
            if (i % 2 == 0) chk("txn_addr_data", e.d, {48'h0, a});
            else if (!eff_rd) chk("txn_wr_data", e.d, wd);
        end
    endtask

    initial begin
        int k, dn;
        rst_L = 1'b0; req_read = 1'b0; req_write = 1'b0; mem_addr = '0; wr_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_success", success, 0);
        chk("rst_send_in", send_in, 0);
        chk("rst_input_ready", input_ready, 0);
        chk("rst_got_result", got_result, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_proto_data", proto_data, 0);
        chk("rst_proto_addr", proto_addr, 7'd5);
        chk("rst_proto_endp", proto_endp, 4'd4);
        rst_L = 1'b1;
        repeat (2) @(negedge clk);

        run_req(0, 0, 0, 16'h1234, 64'hDEADBEEF_CAFEF00D, 64'h0, 0);
        run_req(1, 0, 0, 16'h00FF, 64'h0, 64'h0123456789ABCDEF, 0);
        run_req(0, 0, 0, 16'hA5A5, 64'h1111_2222_3333_4444, 64'h0, 1);
        run_req(1, 0, 0, 16'h0042, 64'h0, 64'hFEED_FACE_0000_0001, 2);
        run_req(1, 0, 0, 16'h0043, 64'h0, 64'hFEED_FACE_0000_0002, 3);
        run_req(0, 1, 1, 16'hBEEF, 64'h5555_AAAA_5555_AAAA, 64'h7777_8888_9999_0000, 0);

        for (int i = 0; i < 20; i++) begin
            run_req($urandom_range(0, 1), ($urandom_range(0, 5) == 0), $urandom_range(0, 1),
                    16'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                    ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
        end

        // Reset while the data phase is outstanding.
        @(negedge clk);
        log_q.delete(); gr_count = 0; cancel_budget = 0; rd_value = 64'h0BAD_0BAD_0BAD_0BAD;
        req_read = 1'b1; mem_addr = 16'h0777;
        @(negedge clk);
        req_read = 1'b0;
        k = 0;
        while (log_q.size() < 2 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("reach_data_phase", log_q.size(), 2);
        @(negedge clk);
        rst_L = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_input_ready", input_ready, 0);
        chk("midrst_rd_data", rd_data, 0);
        chk("midrst_proto_endp", proto_endp, 4'd4);
        chk("midrst_send_in", send_in, 0);
        repeat (2) @(negedge clk);
        rst_L = 1'b1;
        dn = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("no_done_after_reset", dn, 0);
        chk("idle_after_reset", busy, 0);
        run_req(1, 0, 0, 16'h0778, 64'h0, 64'hCAFE_BABE_1234_5678, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/usb_rw_ctrl.md
Name: usb_rw_ctrl

Overview:
- Read/write transaction sequencer sitting between the host-side task interface and ProtocolFSM.
- A memory read or write is split into two protocol transactions:
  - An OUT to the address endpoint carrying the 16-bit memory address.
  - Then an IN (read) or OUT (write) on the data endpoint.
- Drives the protocol FSM's send_in/input_ready/data/addr/endp.
- Tracks free/cancel/recv_ready from the protocol FSM.
- Reports a single done/success pulse per request.

Parameters:
- DEV_ADDR, 7'd5: USB device address driven on proto_addr for every transaction.
- ADDR_ENDP, 4'd4: endpoint receiving the memory-address OUT.
- DATA_ENDP, 4'd8: endpoint for the data IN/OUT.
- MAX_RETRY, 2: whole-request retries after cancel; used only with USB_RW_RETRY_EN.

Ports:
- clk, input, 1: system clock.
- rst_L, input, 1: reset. One clock; reset is asynchronous and active-low.
- req_read, input, 1: start a read; sampled only in IDLE.
- req_write, input, 1: start a write; sampled only in IDLE.
- mem_addr, input, 16: target memory address; captured at request.
- wr_data, input, 64: write payload; captured at request.
- busy, output, 1: high from the cycle after acceptance until done.
- done, output, 1: one-cycle completion pulse.
- success, output, 1: valid with done; 1 = completed, 0 = cancelled.
- rd_data, output, 64: read result; valid from done until the next request.
- send_in, output, 1: 1 = IN transaction, 0 = OUT; held stable for the whole transaction.
- input_ready, output, 1: one-cycle transaction start strobe to the protocol FSM.
- proto_data, output, 64: OUT payload.
- proto_addr, output, 7: device address.
- proto_endp, output, 4: endpoint.
- got_result, output, 1: one-cycle acknowledge that clears the protocol FSM's receive register.
- free, input, 1: protocol FSM idle.
- cancel, input, 1: protocol FSM gave up the transaction.
- recv_ready, input, 1: IN data available.
- data_recv, input, 64: IN data.

Behaviour:
- Reset (asynchronous, rst_L low) values:
  - state = IDLE.
  - busy, done, success, send_in, input_ready, got_result = 0.
  - rd_data, proto_data = 0.
  - proto_addr = DEV_ADDR; proto_endp = ADDR_ENDP.
- Reset mid-operation abandons the request; no done pulse is generated.
- States: IDLE, A_ISSUE, A_WAIT, D_ISSUE, D_WAIT, FINISH.
- IDLE:
  - On req_read or req_write, capture mem_addr, wr_data and op (op = read if req_read, else write), then go to A_ISSUE.
  - Both requests high at once: read wins and req_write is ignored.
  - Requests arriving while busy are ignored; they are not queued.
- A_ISSUE:
  - Wait for free = 1.
  - Then pulse input_ready for one cycle with send_in = 0, proto_endp = ADDR_ENDP, proto_data = {48'h0, mem_addr}.
  - Clear the seen_busy flag; go to A_WAIT.
- A_WAIT:
  - Set seen_busy when free = 0.
  - cancel at any point: go to FINISH with success = 0.
  - free = 1 with seen_busy set: go to D_ISSUE.
  - free = 1 before seen_busy is set: not completion; stay.
- D_ISSUE:
  - Wait for free = 1, then pulse input_ready.
  - proto_endp = DATA_ENDP.
  - send_in = 1 for a read; send_in = 0 with proto_data = captured wr_data for a write.
  - Go to D_WAIT.
- D_WAIT:
  - Same completion/cancel rules as A_WAIT.
  - Read only: on the first recv_ready cycle, capture data_recv into rd_data and pulse got_result the following cycle, exactly once per request.
  - Read completing with free but no recv_ready ever seen: treated as failure, success = 0.
- FINISH:
  - done = 1 for one cycle with success valid; busy drops in the same cycle.
  - Return to IDLE.
- Signal stability:
  - send_in, proto_endp, proto_data and proto_addr are registered.
  - They are held from issue until the next issue, so ProtocolFSM's mux stays stable.
- Latency floor: at least 6 cycles from acceptance to done.

Optional Feature:
- Macro: USB_RW_RETRY_EN.
- Defined:
  - cancel in A_WAIT or D_WAIT increments a retry counter and returns to A_ISSUE, restarting the whole request.
  - done with success = 0 occurs only after MAX_RETRY retries have been exhausted.
  - The counter clears on acceptance.
- Undefined: the first cancel ends the request with success = 0; no counter logic is built.

Decomposition:
- Package usb_rw_pkg holds:
  - The state enum.
  - Op enum {OP_READ, OP_WRITE}.
  - Constants ADDR_ENDP_DEF = 4'd4, DATA_ENDP_DEF = 4'd8, ADDR_PAD_W = 48.
- Sub-module usb_txn_tracker: issue strobe, seen_busy tracking and completion/cancel detection for one transaction.
  - It is instantiated once and reused for both phases.
- The retry count uses the existing counter primitive.

Test Plan:
- Write: req_write, mem_addr = 16'h1234, wr_data = 64'hDEADBEEF_CAFEF00D, model completes both OUTs.
  - Expect input_ready twice.
  - Expect proto_data 64'h1234 then the payload, with endp 4 then 8.
  - Expect done = 1, success = 1.
- Read: req_read, mem_addr = 16'h00FF, model returns 64'h0123456789ABCDEF.
  - Expect second send_in = 1.
  - Expect rd_data = 64'h0123456789ABCDEF.
  - Expect a single got_result pulse; success = 1.
- Cancel on the data phase, macro off: expect done with success = 0 and no further input_ready.
- Cancel twice then success, macro on with MAX_RETRY = 2: expect 6 input_ready pulses total and success = 1.
  - With 3 cancels: success = 0.
- req_read and req_write together in IDLE, then req_write while busy: expect a read op (send_in = 1 on the data phase) and the write ignored.
- rst_L low during D_WAIT:
  - Expect immediate IDLE with busy = 0 and done = 0.
  - A new read afterwards completes normally.
